// File: rtl/syscall_unit_if.sv
// Core <-> syscall unit signal bundle: syscall request, status outputs and
// the valid/ready display drain port.
interface syscall_unit_if #(
  parameter int unsigned DATA_W = 32
);
  logic              en;
  logic [DATA_W-1:0] v0;
  logic [DATA_W-1:0] a0;
  logic              stall;
  logic              halt;
  logic              done;
  logic              bad_code;
  logic [DATA_W-1:0] last_hex;
  logic              hex_valid;
  logic [DATA_W-1:0] hex_data;
  logic              hex_ready;
  logic [15:0]       count;

  modport master (
    output en, v0, a0, hex_ready,
    input  stall, halt, done, bad_code, last_hex, hex_valid, hex_data, count
  );

  modport slave (
    input  en, v0, a0, hex_ready,
    output stall, halt, done, bad_code, last_hex, hex_valid, hex_data, count
  );
endinterface

// File: rtl/syscall_unit.sv
// Syscall execution unit: sticky halt, print FIFO with valid/ready drain, done after drain.
// Optional accepted-syscall counter enabled by defining SYSCALL_COUNT_EN.
module syscall_unit #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned DEPTH      = 8,
  parameter int unsigned HALT_CODE  = 10,
  parameter int unsigned PRINT_CODE = 1
) (
  input logic          clk,
  input logic          reset,
  syscall_unit_if.slave sys_io
);

  localparam int unsigned AW = $clog2(DEPTH);

  localparam logic [DATA_W-1:0] HaltCode  = DATA_W'(HALT_CODE);
  localparam logic [DATA_W-1:0] PrintCode = DATA_W'(PRINT_CODE);
  localparam logic [AW:0]       FullOcc   = (AW + 1)'(DEPTH);
  localparam logic [AW-1:0]     PtrOne    = AW'(1);
  localparam logic [AW:0]       OccOne    = (AW + 1)'(1);

  typedef enum logic [1:0] {
    StRun,
    StDrain,
    StDone
  } state_e;

  state_e state_q, state_d;

  logic              halt_q, halt_d;
  logic              done_q, done_d;
  logic              bad_q, bad_d;
  logic [DATA_W-1:0] last_hex_q, last_hex_d;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [AW:0]       occ_q, occ_d;

  logic in_run, is_print, is_halt;
  logic full, empty;
  logic push, pop, halt_req, bad_req, stall;

  assign in_run   = (state_q == StRun);
  assign is_print = (sys_io.v0 == PrintCode);
  assign is_halt  = (sys_io.v0 == HaltCode);
  assign full     = (occ_q == FullOcc);
  assign empty    = (occ_q == '0);

  // Print takes precedence if the two codes were ever configured equal.
  assign stall    = sys_io.en & in_run & is_print & full;
  assign push     = sys_io.en & in_run & is_print & ~full;
  assign halt_req = sys_io.en & in_run & ~is_print & is_halt;
  assign bad_req  = sys_io.en & in_run & ~is_print & ~is_halt;
  assign pop      = ~empty & sys_io.hex_ready;

  // Control FSM and sticky status
  always_comb begin
    state_d    = state_q;
    bad_d      = bad_q | bad_req;
    last_hex_d = push ? sys_io.a0 : last_hex_q;
    unique case (state_q)
      StRun: begin
        if (halt_req) state_d = StDrain;
      end
      StDrain: begin
        if (empty) state_d = StDone;
      end
      StDone: begin
        state_d = StDone;
      end
      default: begin
        state_d = StRun;
      end
    endcase
    halt_d = (state_d != StRun);
    done_d = (state_d == StDone);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StRun;
      halt_q     <= 1'b0;
      done_q     <= 1'b0;
      bad_q      <= 1'b0;
      last_hex_q <= '0;
    end else begin
      state_q    <= state_d;
      halt_q     <= halt_d;
      done_q     <= done_d;
      bad_q      <= bad_d;
      last_hex_q <= last_hex_d;
    end
  end

  // Display FIFO pointers and occupancy
  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + PtrOne : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PtrOne : rd_ptr_q;
    occ_d    = occ_q;
    if (push && !pop) begin
      occ_d = occ_q + OccOne;
    end else if (pop && !push) begin
      occ_d = occ_q - OccOne;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
    end
  end

  // Storage needs no reset: occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= sys_io.a0;
    end
  end

`ifdef SYSCALL_COUNT_EN
  logic [15:0] count_q, count_d;
  logic        accept;

  assign accept = push | halt_req | bad_req;

  always_comb begin
    count_d = count_q;
    if (accept && (count_q != 16'hFFFF)) begin
      count_d = count_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= 16'h0000;
    end else begin
      count_q <= count_d;
    end
  end

  assign sys_io.count = count_q;
`else
  assign sys_io.count = 16'h0000;
`endif

  assign sys_io.stall     = stall;
  assign sys_io.halt      = halt_q;
  assign sys_io.done      = done_q;
  assign sys_io.bad_code  = bad_q;
  assign sys_io.last_hex  = last_hex_q;
  assign sys_io.hex_valid = ~empty;
  assign sys_io.hex_data  = mem_q[rd_ptr_q];

`ifndef SYNTHESIS
  a_done_implies_halt : assert property (@(posedge clk) disable iff (reset)
    done_q |-> halt_q);
  a_occ_bounded : assert property (@(posedge clk) disable iff (reset)
    occ_q <= FullOcc);
`endif

endmodule

// File: tb/tb_syscall_unit.sv
// Directed self-checking bench for syscall_unit (DEPTH=8, HALT_CODE=10, PRINT_CODE=1).
module tb_syscall_unit;

  logic clk = 1'b0;
  logic reset;

  syscall_unit_if #(.DATA_W(32)) sys_if ();

  syscall_unit #(
    .DATA_W    (32),
    .DEPTH     (8),
    .HALT_CODE (10),
    .PRINT_CODE(1)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .sys_io(sys_if)
  );

  always #5 clk = ~clk;

  int total   = 0;
  int bad     = 0;
  int exp_cnt = 0;

  function automatic logic [15:0] cnt_exp();
`ifdef SYSCALL_COUNT_EN
    return 16'(exp_cnt);
`else
    return 16'h0000;
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    sys_if.en        = 1'b0;
    sys_if.v0        = '0;
    sys_if.a0        = '0;
    sys_if.hex_ready = 1'b0;
  endtask

  task automatic apply_reset();
    idle();
    reset = 1'b1;
    tick();
    tick();
    reset   = 1'b0;
    exp_cnt = 0;
  endtask

  task automatic issue(input logic [31:0] v, input logic [31:0] a);
    sys_if.en = 1'b1;
    sys_if.v0 = v;
    sys_if.a0 = a;
    tick();
    sys_if.en = 1'b0;
  endtask

  task automatic test_reset();
    idle();
    reset = 1'b1;
    #1;
    total++; if (sys_if.halt !== 1'b0) begin bad++; $display("FAIL rst_halt got=%b want=0", sys_if.halt); end
    total++; if (sys_if.done !== 1'b0) begin bad++; $display("FAIL rst_done got=%b want=0", sys_if.done); end
    total++; if (sys_if.bad_code !== 1'b0) begin bad++; $display("FAIL rst_bad got=%b want=0", sys_if.bad_code); end
    total++; if (sys_if.last_hex !== 32'h0) begin bad++; $display("FAIL rst_last got=%h want=0", sys_if.last_hex); end
    total++; if (sys_if.hex_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b want=0", sys_if.hex_valid); end
    total++; if (sys_if.count !== 16'h0) begin bad++; $display("FAIL rst_count got=%h want=0", sys_if.count); end
    tick();
    reset = 1'b0;
    tick();
    total++; if (sys_if.stall !== 1'b0) begin bad++; $display("FAIL rst_stall got=%b want=0", sys_if.stall); end
    total++; if (sys_if.halt !== 1'b0) begin bad++; $display("FAIL rst_halt2 got=%b want=0", sys_if.halt); end
  endtask

  task automatic test_print();
    issue(32'd1, 32'h12345678);
    exp_cnt++;
    total++; if (sys_if.hex_valid !== 1'b1) begin bad++; $display("FAIL print_valid got=%b want=1", sys_if.hex_valid); end
    total++; if (sys_if.hex_data !== 32'h12345678) begin bad++; $display("FAIL print_data got=%h want=12345678", sys_if.hex_data); end
    total++; if (sys_if.last_hex !== 32'h12345678) begin bad++; $display("FAIL print_last got=%h want=12345678", sys_if.last_hex); end
    total++; if (sys_if.halt !== 1'b0) begin bad++; $display("FAIL print_halt got=%b want=0", sys_if.halt); end
    total++; if (sys_if.count !== cnt_exp()) begin bad++; $display("FAIL print_count got=%h want=%h", sys_if.count, cnt_exp()); end
    sys_if.hex_ready = 1'b1;
    tick();
    total++; if (sys_if.hex_valid !== 1'b0) begin bad++; $display("FAIL print_pop got=%b want=0", sys_if.hex_valid); end
    // push into an empty FIFO with ready already high must not bypass
    issue(32'd1, 32'hCAFE0001);
    exp_cnt++;
    total++; if (sys_if.hex_valid !== 1'b1) begin bad++; $display("FAIL nobypass_valid got=%b want=1", sys_if.hex_valid); end
    total++; if (sys_if.hex_data !== 32'hCAFE0001) begin bad++; $display("FAIL nobypass_data got=%h want=cafe0001", sys_if.hex_data); end
    tick();
    total++; if (sys_if.hex_valid !== 1'b0) begin bad++; $display("FAIL nobypass_pop got=%b want=0", sys_if.hex_valid); end
    sys_if.hex_ready = 1'b0;
  endtask

  task automatic test_full_wrap();
    sys_if.hex_ready = 1'b0;
    sys_if.en        = 1'b1;
    sys_if.v0        = 32'd1;
    for (int i = 0; i < 8; i++) begin
      sys_if.a0 = 32'(i);
      #1;
      total++; if (sys_if.stall !== 1'b0) begin bad++; $display("FAIL fill_stall[%0d] got=%b want=0", i, sys_if.stall); end
      tick();
      exp_cnt++;
    end
    sys_if.a0 = 32'd8;
    #1;
    total++; if (sys_if.stall !== 1'b1) begin bad++; $display("FAIL full_stall got=%b want=1", sys_if.stall); end
    tick();
    total++; if (sys_if.last_hex !== 32'd7) begin bad++; $display("FAIL full_last got=%h want=7", sys_if.last_hex); end
    total++; if (sys_if.count !== cnt_exp()) begin bad++; $display("FAIL full_count got=%h want=%h", sys_if.count, cnt_exp()); end
    sys_if.hex_ready = 1'b1;
    #1;
    total++; if (sys_if.stall !== 1'b1) begin bad++; $display("FAIL stall_with_pop got=%b want=1", sys_if.stall); end
    total++; if (sys_if.hex_data !== 32'd0) begin bad++; $display("FAIL drain_data[0] got=%h want=0", sys_if.hex_data); end
    tick();
    sys_if.en = 1'b0;
    for (int i = 1; i < 8; i++) begin
      total++; if (sys_if.hex_valid !== 1'b1) begin bad++; $display("FAIL drain_valid[%0d] got=%b want=1", i, sys_if.hex_valid); end
      total++; if (sys_if.hex_data !== 32'(i)) begin bad++; $display("FAIL drain_data[%0d] got=%h want=%h", i, sys_if.hex_data, i); end
      tick();
    end
    total++; if (sys_if.hex_valid !== 1'b0) begin bad++; $display("FAIL drain_empty got=%b want=0", sys_if.hex_valid); end
    total++; if (sys_if.count !== cnt_exp()) begin bad++; $display("FAIL drain_count got=%h want=%h", sys_if.count, cnt_exp()); end
    sys_if.hex_ready = 1'b0;
    issue(32'd1, 32'd100);
    exp_cnt++;
    sys_if.hex_ready = 1'b1;
    sys_if.en        = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      sys_if.a0 = 32'(100 + k);
      #1;
      total++; if (sys_if.hex_data !== 32'(99 + k)) begin bad++; $display("FAIL wrap_data[%0d] got=%h want=%h", k, sys_if.hex_data, 99 + k); end
      total++; if (sys_if.stall !== 1'b0) begin bad++; $display("FAIL wrap_stall[%0d] got=%b want=0", k, sys_if.stall); end
      tick();
      exp_cnt++;
    end
    sys_if.en = 1'b0;
    total++; if (sys_if.hex_data !== 32'd108) begin bad++; $display("FAIL wrap_tail got=%h want=6c", sys_if.hex_data); end
    total++; if (sys_if.last_hex !== 32'd108) begin bad++; $display("FAIL wrap_last got=%h want=6c", sys_if.last_hex); end
    tick();
    total++; if (sys_if.hex_valid !== 1'b0) begin bad++; $display("FAIL wrap_empty got=%b want=0", sys_if.hex_valid); end
    total++; if (sys_if.count !== cnt_exp()) begin bad++; $display("FAIL wrap_count got=%h want=%h", sys_if.count, cnt_exp()); end
    sys_if.hex_ready = 1'b0;
  endtask

  task automatic test_halt_drain();
    issue(32'd1, 32'h000000A1);
    issue(32'd1, 32'h000000A2);
    exp_cnt += 2;
    issue(32'd10, 32'hABCD1234);
    exp_cnt++;
    total++; if (sys_if.halt !== 1'b1) begin bad++; $display("FAIL halt_rise got=%b want=1", sys_if.halt); end
    total++; if (sys_if.done !== 1'b0) begin bad++; $display("FAIL halt_done got=%b want=0", sys_if.done); end
    total++; if (sys_if.last_hex !== 32'hA2) begin bad++; $display("FAIL halt_last got=%h want=a2", sys_if.last_hex); end
    sys_if.en = 1'b1;
    sys_if.v0 = 32'd1;
    sys_if.a0 = 32'hFFFF0000;
    #1;
    total++; if (sys_if.stall !== 1'b0) begin bad++; $display("FAIL drain_nostall got=%b want=0", sys_if.stall); end
    tick();
    sys_if.v0 = 32'd7;
    tick();
    sys_if.en = 1'b0;
    total++; if (sys_if.hex_data !== 32'hA1) begin bad++; $display("FAIL drain_ignore_data got=%h want=a1", sys_if.hex_data); end
    total++; if (sys_if.bad_code !== 1'b0) begin bad++; $display("FAIL drain_ignore_bad got=%b want=0", sys_if.bad_code); end
    total++; if (sys_if.count !== cnt_exp()) begin bad++; $display("FAIL drain_ignore_count got=%h want=%h", sys_if.count, cnt_exp()); end
    total++; if (sys_if.done !== 1'b0) begin bad++; $display("FAIL drain_wait_done got=%b want=0", sys_if.done); end
    sys_if.hex_ready = 1'b1;
    tick();
    total++; if (sys_if.hex_data !== 32'hA2) begin bad++; $display("FAIL drain_second got=%h want=a2", sys_if.hex_data); end
    total++; if (sys_if.done !== 1'b0) begin bad++; $display("FAIL drain_one_left_done got=%b want=0", sys_if.done); end
    tick();
    sys_if.hex_ready = 1'b0;
    total++; if (sys_if.hex_valid !== 1'b0) begin bad++; $display("FAIL drain_empty_valid got=%b want=0", sys_if.hex_valid); end
    total++; if (sys_if.done !== 1'b0) begin bad++; $display("FAIL drain_empty_done got=%b want=0", sys_if.done); end
    tick();
    total++; if (sys_if.done !== 1'b1) begin bad++; $display("FAIL done_rise got=%b want=1", sys_if.done); end
    total++; if (sys_if.halt !== 1'b1) begin bad++; $display("FAIL done_halt got=%b want=1", sys_if.halt); end
    sys_if.en = 1'b1;
    sys_if.v0 = 32'd1;
    sys_if.a0 = 32'hFFFFFFFF;
    #1;
    total++; if (sys_if.stall !== 1'b0) begin bad++; $display("FAIL done_nostall got=%b want=0", sys_if.stall); end
    tick();
    sys_if.en = 1'b0;
    total++; if (sys_if.hex_valid !== 1'b0) begin bad++; $display("FAIL done_valid got=%b want=0", sys_if.hex_valid); end
    total++; if (sys_if.last_hex !== 32'hA2) begin bad++; $display("FAIL done_last got=%h want=a2", sys_if.last_hex); end
    total++; if (sys_if.count !== cnt_exp()) begin bad++; $display("FAIL done_count got=%h want=%h", sys_if.count, cnt_exp()); end
    total++; if (sys_if.done !== 1'b1) begin bad++; $display("FAIL done_hold got=%b want=1", sys_if.done); end
  endtask

  task automatic test_bad_code();
    apply_reset();
    issue(32'd7, 32'h0);
    exp_cnt++;
    total++; if (sys_if.bad_code !== 1'b1) begin bad++; $display("FAIL bad_set got=%b want=1", sys_if.bad_code); end
    total++; if (sys_if.hex_valid !== 1'b0) begin bad++; $display("FAIL bad_nopush got=%b want=0", sys_if.hex_valid); end
    total++; if (sys_if.halt !== 1'b0) begin bad++; $display("FAIL bad_nohalt got=%b want=0", sys_if.halt); end
    issue(32'd1, 32'h55);
    exp_cnt++;
    total++; if (sys_if.bad_code !== 1'b1) begin bad++; $display("FAIL bad_sticky1 got=%b want=1", sys_if.bad_code); end
    issue(32'd10, 32'h0);
    exp_cnt++;
    total++; if (sys_if.bad_code !== 1'b1) begin bad++; $display("FAIL bad_sticky2 got=%b want=1", sys_if.bad_code); end
    total++; if (sys_if.count !== cnt_exp()) begin bad++; $display("FAIL bad_count got=%h want=%h", sys_if.count, cnt_exp()); end
  endtask

  task automatic test_code_width();
    apply_reset();
    issue(32'h00010001, 32'h77);
    exp_cnt++;
    total++; if (sys_if.bad_code !== 1'b1) begin bad++; $display("FAIL wide_print_bad got=%b want=1", sys_if.bad_code); end
    total++; if (sys_if.hex_valid !== 1'b0) begin bad++; $display("FAIL wide_print_nopush got=%b want=0", sys_if.hex_valid); end
    total++; if (sys_if.last_hex !== 32'h0) begin bad++; $display("FAIL wide_print_last got=%h want=0", sys_if.last_hex); end
    issue(32'h8000000A, 32'h0);
    exp_cnt++;
    total++; if (sys_if.halt !== 1'b0) begin bad++; $display("FAIL wide_halt got=%b want=0", sys_if.halt); end
    total++; if (sys_if.count !== cnt_exp()) begin bad++; $display("FAIL wide_count got=%h want=%h", sys_if.count, cnt_exp()); end
  endtask

  task automatic test_reset_mid_drain();
    apply_reset();
    issue(32'd1, 32'h11);
    issue(32'd1, 32'h22);
    issue(32'd1, 32'h33);
    issue(32'd10, 32'h0);
    total++; if (sys_if.halt !== 1'b1) begin bad++; $display("FAIL mid_halt got=%b want=1", sys_if.halt); end
    total++; if (sys_if.hex_valid !== 1'b1) begin bad++; $display("FAIL mid_valid got=%b want=1", sys_if.hex_valid); end
    #2;
    reset = 1'b1;
    #1;
    total++; if (sys_if.halt !== 1'b0) begin bad++; $display("FAIL async_halt got=%b want=0", sys_if.halt); end
    total++; if (sys_if.done !== 1'b0) begin bad++; $display("FAIL async_done got=%b want=0", sys_if.done); end
    total++; if (sys_if.hex_valid !== 1'b0) begin bad++; $display("FAIL async_valid got=%b want=0", sys_if.hex_valid); end
    total++; if (sys_if.last_hex !== 32'h0) begin bad++; $display("FAIL async_last got=%h want=0", sys_if.last_hex); end
    total++; if (sys_if.count !== 16'h0) begin bad++; $display("FAIL async_count got=%h want=0", sys_if.count); end
    tick();
    reset = 1'b0;
    tick();
    total++; if (sys_if.hex_valid !== 1'b0) begin bad++; $display("FAIL post_reset_valid got=%b want=0", sys_if.hex_valid); end
  endtask

  initial begin
    test_reset();
    test_print();
    test_full_wrap();
    test_halt_drain();
    test_bad_code();
    test_code_width();
    test_reset_mid_drain();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
